// File: rtl/sensor_scan_sequencer.sv
// rtl/sensor_scan_sequencer.sv - tick-driven sensor channel scanner with sample FIFO and Avalon-MM register slave

// Sample queue: simultaneous push and pop are both honoured, so a push into a full queue succeeds when a pop happens on the same cycle.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [4:0]       level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == 5'(DEPTH));
  assign empty   = (level == 5'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointer and level bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= 5'd0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
    end
  end
endmodule

module sensor_scan_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 12,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_in,
  output logic              sens_start,
  output logic [1:0]        sens_ch,
  input  logic              sens_done,
  input  logic [DATA_W-1:0] sens_data,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic              irq
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] STORE = 2'd3;

  localparam int         CW       = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [3:0] CH_MASK  = 4'((1 << NUM_CH) - 1);

  logic [1:0]    state;
  logic [1:0]    ch;
  logic [CW-1:0] cnt;
  logic [11:0]   sample;
  logic          timed_out;
  logic          abort;

  logic          enable;
  logic          irq_en;
  logic [3:0]    mask;
  logic [4:0]    thresh;
  logic          overflow;

  logic          tick_q;
  logic          rd_q;
  logic          wr_en;
  logic          rd_qual;
  logic          pop;
  logic          ctrl_wr;
  logic          soft_trig;
  logic          scan_req;
  logic          busy;
  logic [3:0]    eff_mask;
  logic [1:0]    first_ch;
  logic [1:0]    next_ch;
  logic          has_next;
  logic          store;

  logic [15:0]   head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [4:0]    level;
  logic [4:0]    thresh_eff;
  logic          unused_bits;

  assign wr_en     = chipselect && !write_n;
  assign rd_qual   = chipselect && !read_n && (address == 2'd0);
  assign pop       = rd_qual && !rd_q && !fifo_empty;
  assign ctrl_wr   = wr_en && (address == 2'd2);
  assign soft_trig = ctrl_wr && writedata[2];
  assign scan_req  = (enable && tick_in && !tick_q) || soft_trig;
  assign busy      = (state != IDLE);
  assign eff_mask  = mask & CH_MASK;
  assign store     = (state == STORE);

  assign sens_start  = (state == SCAN);
  assign sens_ch     = ch;
  assign thresh_eff  = (thresh == 5'd0) ? 5'd1 : thresh;
  assign irq         = irq_en && (level >= thresh_eff);
  assign unused_bits = ^{writedata[15:9], writedata[3]};

  // Pick the lowest enabled channel to start from and the next enabled one above the current channel.
  always_comb begin
    first_ch = 2'd0;
    next_ch  = 2'd0;
    has_next = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (eff_mask[i]) begin
        first_ch = 2'(i);
        if (2'(i) > ch) begin
          next_ch  = 2'(i);
          has_next = 1'b1;
        end
      end
    end
  end

  sample_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (store),
    .pop   (pop),
    .wdata ({1'b1, timed_out, ch, sample}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Edge detectors for the timer tick and the DATA read strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= 1'b0;
      rd_q   <= 1'b0;
    end else begin
      tick_q <= tick_in;
      rd_q   <= rd_qual;
    end
  end

  // Scan FSM: start pulse, wait for done or timeout, store, then advance to the next channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ch        <= 2'd0;
      cnt       <= '0;
      sample    <= 12'd0;
      timed_out <= 1'b0;
      abort     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_req && (eff_mask != 4'd0)) begin
            state <= SCAN;
            ch    <= first_ch;
            abort <= 1'b0;
          end
        end
        SCAN: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (sens_done) begin
            sample    <= 12'(sens_data);
            timed_out <= 1'b0;
            state     <= STORE;
          end else if (cnt == CNT_LAST) begin
            sample    <= 12'd0;
            timed_out <= 1'b1;
            state     <= STORE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (has_next && !abort) begin
            ch    <= next_ch;
            state <= SCAN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
      // Clearing enable mid-scan lets the current channel finish, then stops.
      if (busy && ctrl_wr && !writedata[0]) abort <= 1'b1;
    end
  end

  // Software-visible control registers and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      mask     <= 4'd0;
      thresh   <= 5'd1;
      overflow <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        enable <= writedata[0];
        irq_en <= writedata[1];
        mask   <= writedata[7:4];
      end
      if (wr_en && (address == 2'd3)) thresh <= writedata[4:0];
      if (store && fifo_full && !pop) overflow <= 1'b1;
      else if (wr_en && (address == 2'd1) && writedata[8]) overflow <= 1'b0;
    end
  end

  // Registered read mux; DATA shows the popped entry and holds it for the rest of a long strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= 16'h0000;
    end else begin
      case (address)
        2'd0: begin
          if (pop)                 readdata <= head;
          else if (rd_qual && rd_q) readdata <= readdata;
          else                     readdata <= 16'h0000;
        end
        2'd1:    readdata <= {6'd0, busy, overflow, 3'd0, level};
        2'd2:    readdata <= {8'd0, mask, 2'b00, irq_en, enable};
        default: readdata <= {11'd0, thresh};
      endcase
    end
  end
endmodule

// File: doc/sensor_scan_sequencer.md
Name: sensor_scan_sequencer

Overview:
- Sits directly downstream of the interval timer and consumes its irq output as a periodic scan tick.
- On each tick, walks the enabled sensor channels one at a time:
  - pulses a start request to the sensor front-end;
  - waits for done or timeout;
  - pushes a tagged sample into an internal FIFO.
- Nios software drains the FIFO over a 16-bit Avalon-MM slave and gets an interrupt when the FIFO reaches a programmed level.

Parameters:
- NUM_CH, 4, number of sensor channels (1..4); channel index is 2 bits.
- DATA_W, 12, sensor sample width (<=12).
- FIFO_DEPTH, 16, sample FIFO entries (power of 2, <=16).
- TIMEOUT_CYC, 1000, cycles to wait for sens_done before tagging a timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick_in  in  1  timer irq (level); a rising edge starts a scan.
- sens_start  out  1  one-cycle start pulse to the sensor front-end.
- sens_ch  out  2  channel being converted; held stable from sens_start until done/timeout.
- sens_done  in  1  one-cycle pulse, sample valid.
- sens_data  in  DATA_W  sample, sampled only when sens_done=1.
- address  in  2  Avalon register select.
- chipselect  in  1  Avalon chip select.
- read_n  in  1  Avalon read, active low.
- write_n  in  1  Avalon write, active low.
- writedata  in  16  Avalon write data.
- readdata  out  16  Avalon read data, registered.
- irq  out  1  FIFO-level interrupt.

Behaviour:
- Reset (synchronous, active-high) values:
  - outputs: sens_start=0, sens_ch=0, readdata=0, irq=0;
  - registers: CONTROL=0, THRESH=1, FIFO empty, overflow=0, FSM=IDLE.
- Register map:
  - 0 DATA, read only. Read pops one FIFO entry.
    - Fields: [15]=valid, [14]=timeout, [13:12]=channel, [11:0]=data, zero-extended.
    - Reading while the FIFO is empty returns 0x0000 with no pop.
  - 1 STATUS.
    - Read fields: [4:0]=fill level, [8]=overflow, [9]=busy (FSM not IDLE).
    - Write with [8]=1 clears overflow.
  - 2 CONTROL, read/write.
    - [0]=enable, [1]=irq_en, [7:4]=channel mask.
    - [2]=soft trigger: write-only, self-clearing, reads as 0.
  - 3 THRESH, read/write.
    - [4:0]=irq level; a value of 0 is treated as 1.
- readdata is registered with 1-cycle latency; it is updated every cycle from the address mux, as the timer does.
  - A DATA pop occurs on the cycle chipselect && !read_n && address==0 && FIFO not empty.
  - The readdata loaded on that cycle holds the popped entry.
  - A multi-cycle read strobe pops only on its first cycle: rising edge of the read qualifier.
- Tick detect: tick_q registers tick_in. scan_req = enable && tick_in && !tick_q, OR a soft-trigger write.
- Scan requests while busy are dropped; no queuing.
- FSM:
  - IDLE -> SCAN when scan_req and mask!=0; ch = lowest set mask bit. With mask=0, stay IDLE.
  - SCAN: sens_start=1 for exactly one cycle, sens_ch=ch; clear the timeout counter; -> WAIT.
  - WAIT:
    - on sens_done: latch data with timeout=0; -> STORE;
    - on counter==TIMEOUT_CYC-1 without done: data=0, timeout=1; -> STORE.
    - sens_done on the same cycle as expiry counts as done.
  - STORE: push {1,timeout,ch,data}.
    - If FIFO full: drop the entry, set overflow; FIFO contents unchanged.
    - -> SCAN with the next higher set mask bit, or -> IDLE if none remain.
  - enable cleared mid-scan: the current channel completes; the FSM then returns to IDLE.
  - Channels >= NUM_CH are ignored in the mask.
- FIFO: simultaneous push and pop in the same cycle are both honoured and the level is unchanged. This includes pop-from-full plus push, which does not overflow.
- irq = irq_en && (level >= max(THRESH,1)); combinational from registered state. It drops once reads bring level below the threshold.
- Worst-case scan time per channel: 1 (SCAN) + TIMEOUT_CYC + 1 (STORE).

Test Plan:
- Reset, then read all four registers -> DATA=0x0000, STATUS=0x0000, CONTROL=0x0000, THRESH=0x0001; irq=0, sens_start=0.
- Basic scan:
  - stimulus: CONTROL=0x0031 (mask 0b0011, enable, irq_en off), THRESH=2; tick_in rising; front-end answers done after 5 cycles with 0xABC (ch0), then 0x123 (ch1);
  - response: sens_start pulses with sens_ch=0, then sens_ch=1; level=2; DATA reads return 0x8ABC, then 0x9123, then 0x0000.
- Interrupt:
  - stimulus: set irq_en (CONTROL=0x0033); repeat the scan;
  - response: irq rises when level reaches 2; one DATA read drops irq; a second read empties the FIFO.
- Timeout: mask=0b0100, no sens_done -> after TIMEOUT_CYC cycles the entry is 0xE000 (valid, timeout, ch2).
- Overflow:
  - stimulus: mask=0b0001; 17 ticks without reads;
  - response: level=16, STATUS[8]=1; the 17th sample is dropped; writing STATUS=0x0100 clears overflow.
- Edge cases:
  - tick_in held high for 50 cycles -> exactly one scan;
  - a tick during a scan is ignored;
  - soft trigger (CONTROL write with [2]=1) with enable=0 -> one scan;
  - reset asserted in WAIT -> FSM IDLE, FIFO empty the next cycle.
